// File: rtl/tensor_addr_gen.sv
// tensor_addr_gen: im2col tensor-side read address generator.
// Walks an HWC input tensor with incremental pointers, emitting one read
// address per accepted beat: kc contiguous words per kernel row, ksize kernel
// rows per output pixel, ofs x ofs output pixels.
//
// Optional feature: define TADDR_BASE_EN to add the i_base port; every
// address is then offset by the base latched at start. Without it the base
// is fixed at 0.
//
// Ports:
//   clk, rstn                      clock, async active-low reset
//   enable                         start pulse, honoured only in IDLE
//   i_kc, i_ksize, i_ofs           run length, kernel rows, output side
//   i_row_pitch, i_scan, i_sran    row pitch, column step, row step
//   i_base                         base address (TADDR_BASE_EN only)
//   o_addr, o_valid, i_ready       address beat with valid/ready handshake
//   o_row_last                     last beat of an im2col row
//   o_busy                         high in LOAD and RUN
//   o_done                         one-cycle pulse after the final accept
module tensor_addr_gen #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic [CNT_W-1:0]  i_kc,
  input  logic [CNT_W-1:0]  i_ksize,
  input  logic [CNT_W-1:0]  i_ofs,
  input  logic [ADDR_W-1:0] i_row_pitch,
  input  logic [ADDR_W-1:0] i_scan,
  input  logic [ADDR_W-1:0] i_sran,
`ifdef TADDR_BASE_EN
  input  logic [ADDR_W-1:0] i_base,
`endif
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_row_last,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Shadow copies of the configuration, captured at start
  logic [CNT_W-1:0]  kc_q, kc_d, ksize_q, ksize_d, ofs_q, ofs_d;
  logic [ADDR_W-1:0] pitch_q, pitch_d, scan_q, scan_d, sran_q, sran_d;
  logic [ADDR_W-1:0] base_q, base_d, base_in;

  // Loop counters and incremental pointers
  logic [CNT_W-1:0]  r_q, r_d, ky_q, ky_d, ox_q, ox_d, oy_q, oy_d;
  logic [ADDR_W-1:0] krow_q, krow_d, pix_q, pix_d, rs_q, rs_d;

  logic [ADDR_W-1:0] addr_d;
  logic              valid_d, row_last_d, busy_d, done_d;

  logic [CNT_W-1:0]  kc_m1, ksize_m1, ofs_m1;
  logic              r_last, ky_last, ox_last, oy_last, fin;

`ifdef TADDR_BASE_EN
  assign base_in = i_base;
`else
  assign base_in = '0;
`endif

  assign kc_m1    = kc_q - CNT_W'(1);
  assign ksize_m1 = ksize_q - CNT_W'(1);
  assign ofs_m1   = ofs_q - CNT_W'(1);
  assign r_last   = (r_q == kc_m1);
  assign ky_last  = (ky_q == ksize_m1);
  assign ox_last  = (ox_q == ofs_m1);
  assign oy_last  = (oy_q == ofs_m1);
  assign fin      = r_last && ky_last && ox_last && oy_last;

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      kc_q       <= '0;
      ksize_q    <= '0;
      ofs_q      <= '0;
      pitch_q    <= '0;
      scan_q     <= '0;
      sran_q     <= '0;
      base_q     <= '0;
      r_q        <= '0;
      ky_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      krow_q     <= '0;
      pix_q      <= '0;
      rs_q       <= '0;
      o_addr     <= '0;
      o_valid    <= 1'b0;
      o_row_last <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state_q    <= state_d;
      kc_q       <= kc_d;
      ksize_q    <= ksize_d;
      ofs_q      <= ofs_d;
      pitch_q    <= pitch_d;
      scan_q     <= scan_d;
      sran_q     <= sran_d;
      base_q     <= base_d;
      r_q        <= r_d;
      ky_q       <= ky_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      krow_q     <= krow_d;
      pix_q      <= pix_d;
      rs_q       <= rs_d;
      o_addr     <= addr_d;
      o_valid    <= valid_d;
      o_row_last <= row_last_d;
      o_busy     <= busy_d;
      o_done     <= done_d;
    end
  end

  // Next-state, counter stepping and next-output logic
  always_comb begin
    state_d    = state_q;
    kc_d       = kc_q;
    ksize_d    = ksize_q;
    ofs_d      = ofs_q;
    pitch_d    = pitch_q;
    scan_d     = scan_q;
    sran_d     = sran_q;
    base_d     = base_q;
    r_d        = r_q;
    ky_d       = ky_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    krow_d     = krow_q;
    pix_d      = pix_q;
    rs_d       = rs_q;
    addr_d     = o_addr;
    valid_d    = o_valid;
    row_last_d = o_row_last;
    busy_d     = o_busy;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        valid_d    = 1'b0;
        row_last_d = 1'b0;
        busy_d     = 1'b0;
        if (enable) begin
          kc_d    = i_kc;
          ksize_d = i_ksize;
          ofs_d   = i_ofs;
          pitch_d = i_row_pitch;
          scan_d  = i_scan;
          sran_d  = i_sran;
          base_d  = base_in;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        r_d    = '0;
        ky_d   = '0;
        ox_d   = '0;
        oy_d   = '0;
        krow_d = base_q;
        pix_d  = base_q;
        rs_d   = base_q;
        if ((kc_q == '0) || (ksize_q == '0) || (ofs_q == '0)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          addr_d     = base_q;
          valid_d    = 1'b1;
          row_last_d = (kc_m1 == '0) && (ksize_m1 == '0);
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        if (o_valid && i_ready) begin
          if (fin) begin
            r_d        = '0;
            ky_d       = '0;
            ox_d       = '0;
            oy_d       = '0;
            valid_d    = 1'b0;
            row_last_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = S_DONE;
          end else begin
            // Innermost counter first; each wrap carries into the next level
            if (!r_last) begin
              r_d    = r_q + CNT_W'(1);
              addr_d = krow_q + ADDR_W'(r_d);
            end else begin
              r_d = '0;
              if (!ky_last) begin
                ky_d   = ky_q + CNT_W'(1);
                krow_d = krow_q + pitch_q;
              end else begin
                ky_d = '0;
                if (!ox_last) begin
                  ox_d  = ox_q + CNT_W'(1);
                  pix_d = pix_q + scan_q;
                end else begin
                  ox_d  = '0;
                  oy_d  = oy_q + CNT_W'(1);
                  rs_d  = rs_q + sran_q;
                  pix_d = rs_d;
                end
                krow_d = pix_d;
              end
              addr_d = krow_d;
            end
            row_last_d = (r_d == kc_m1) && (ky_d == ksize_m1);
          end
        end
      end

      S_DONE: begin
        valid_d    = 1'b0;
        row_last_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
